// File: rtl/cpu_8096_alu_seq.sv
// cpu_8096_alu_seq
// Registered ALU execution unit for the 8096 core, operand width WIDTH (8/16/32).
// Single-cycle ops: ADD, ADC, SUB, SBB, AND, OR, XOR, CMP.
// Iterative ops: MUL/IMUL (shift-add) and DIV/IDIV (restoring division).
// Flags follow the 8086 subset CF, PF, AF, ZF, SF, OF.
//
// Ports
//   clk, rst                 core clock, asynchronous active-high reset
//   in_valid / in_ready      request handshake; in_op, in_a, in_b, in_cf sampled at accept
//   out_valid / out_ready    result handshake; out_* held while out_valid && !out_ready
//   out_lo / out_hi          result (or product low/high halves, or quotient/remainder)
//   out_cf..out_of           result flags
//   out_div_err              divisor zero or signed quotient overflow
module cpu_8096_alu_seq #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lo,
  output logic [WIDTH-1:0] out_hi,
  output logic             out_cf,
  output logic             out_pf,
  output logic             out_af,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic             out_div_err
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADC  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SBB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_CMP  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_IMUL = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_IDIV = 4'd11;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  // Flag vectors are ordered {cf, pf, af, zf, sf, of}.
  function automatic logic [5:0] res_flags(input logic [WIDTH-1:0] r, input logic cf,
                                           input logic af, input logic of);
    return {cf, ~^r[7:0], af, (r == '0), r[WIDTH-1], of};
  endfunction

  // One iteration of the shared datapath. {acc, shf} is the double-width
  // working register: product (acc = high half) or remainder/quotient.
  function automatic logic [2*WIDTH-1:0] iter_step(input logic div,
                                                   input logic [WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0] shf,
                                                   input logic [WIDTH-1:0] opb);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;
    sum   = {1'b0, acc} + (shf[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    trial = {acc, shf[WIDTH-1]};
    diff  = trial[WIDTH-1:0] - opb;
    if (!div) begin
      // shift-add: conditionally add multiplicand, then shift {carry, acc, shf} right
      return {sum, shf[WIDTH-1:1]};
    end else if (trial >= {1'b0, opb}) begin
      return {diff, shf[WIDTH-2:0], 1'b1};
    end else begin
      return {trial[WIDTH-1:0], shf[WIDTH-2:0], 1'b0};
    end
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             is_signed_q, is_signed_d;
  logic             neg_q, neg_d;     // product / quotient sign
  logic             rneg_q, rneg_d;   // remainder sign (dividend sign)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] shf_q, shf_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [5:0]       flags_q, flags_d;
  logic             div_err_q, div_err_d;

  // Request decode
  logic             accept;
  logic             op_iter, op_signed, op_div, div_err_now;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [2*WIDTH-1:0] step_load, step_busy;

  assign in_ready    = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
  assign accept      = in_valid && in_ready;
  assign op_iter     = (in_op >= OP_MUL) && (in_op <= OP_IDIV);
  assign op_signed   = (in_op == OP_IMUL) || (in_op == OP_IDIV);
  assign op_div      = (in_op == OP_DIV) || (in_op == OP_IDIV);
  assign mag_a       = (op_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign mag_b       = (op_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  assign div_err_now = op_div && ((in_b == '0) ||
                       ((in_op == OP_IDIV) && (in_a == MOST_NEG) && (in_b == '1)));

  // The first iteration happens on the accept edge, so BUSY runs WIDTH-1 more
  // iterations plus the finalize cycle: WIDTH+1 edges in total.
  assign step_load = iter_step(op_div, '0, mag_a, mag_b);
  assign step_busy = iter_step(is_div_q, acc_q, shf_q, opb_q);

  // Single-cycle ALU
  logic             carry_in;
  logic [WIDTH:0]   add_full, sub_full;
  logic [WIDTH-1:0] alu_res, alu_lo;
  logic             alu_cf, alu_af, alu_of;
  logic [5:0]       alu_flags;

  always_comb begin
    carry_in  = in_cf && ((in_op == OP_ADC) || (in_op == OP_SBB));
    add_full  = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, carry_in};
    sub_full  = {1'b0, in_a} - {1'b0, in_b} - {{WIDTH{1'b0}}, carry_in};
    alu_res   = '0;
    alu_cf    = 1'b0;
    alu_af    = 1'b0;
    alu_of    = 1'b0;
    case (in_op)
      OP_ADD, OP_ADC: begin
        alu_res = add_full[WIDTH-1:0];
        alu_cf  = add_full[WIDTH];
        alu_af  = in_a[4] ^ in_b[4] ^ alu_res[4];
        alu_of  = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_cf  = sub_full[WIDTH];
        alu_af  = in_a[4] ^ in_b[4] ^ alu_res[4];
        alu_of  = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (alu_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      default: alu_res = '0;  // reserved codes behave as AND with b=0
    endcase
    alu_flags = res_flags(alu_res, alu_cf, alu_af, alu_of);
    alu_lo    = (in_op == OP_CMP) ? in_a : alu_res;
  end

  // Finalize: two's-complement fixup of the unsigned iterative result
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   mul_lo, mul_hi, quo, rem;
  logic               mul_ovf;

  assign prod_raw = {acc_q, shf_q};
  assign prod_fix = neg_q ? -prod_raw : prod_raw;
  assign mul_lo   = prod_fix[WIDTH-1:0];
  assign mul_hi   = prod_fix[2*WIDTH-1:WIDTH];
  assign mul_ovf  = is_signed_q ? (mul_hi != {WIDTH{mul_lo[WIDTH-1]}}) : (mul_hi != '0);
  assign quo      = neg_q ? -shf_q : shf_q;
  assign rem      = rneg_q ? -acc_q : acc_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    acc_d       = acc_q;
    shf_d       = shf_q;
    opb_d       = opb_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    flags_d     = flags_q;
    div_err_d   = div_err_q;

    case (state_q)
      S_BUSY: begin
        if (cnt_q != '0) begin
          {acc_d, shf_d} = step_busy;
          cnt_d          = cnt_q - CNT_W'(1);
        end else begin
          state_d   = S_DONE;
          div_err_d = 1'b0;
          if (is_div_q) begin
            lo_d    = quo;
            hi_d    = rem;
            flags_d = '0;
          end else begin
            lo_d    = mul_lo;
            hi_d    = mul_hi;
            flags_d = res_flags(mul_lo, mul_ovf, 1'b0, mul_ovf);
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // A new request overrides the DONE->IDLE drop (back-to-back issue).
    if (accept) begin
      if (op_iter && !div_err_now) begin
        state_d        = S_BUSY;
        cnt_d          = CNT_W'(WIDTH - 1);
        is_div_d       = op_div;
        is_signed_d    = op_signed;
        neg_d          = op_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        rneg_d         = op_signed && op_div && in_a[WIDTH-1];
        opb_d          = mag_b;
        {acc_d, shf_d} = step_load;
      end else if (div_err_now) begin
        state_d   = S_DONE;
        lo_d      = '0;
        hi_d      = '0;
        flags_d   = '0;
        div_err_d = 1'b1;
      end else begin
        state_d   = S_DONE;
        lo_d      = alu_lo;
        hi_d      = '0;
        flags_d   = alu_flags;
        div_err_d = 1'b0;
      end
    end

    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      acc_q       <= '0;
      shf_q       <= '0;
      opb_q       <= '0;
      out_valid_q <= 1'b0;
      lo_q        <= '0;
      hi_q        <= '0;
      flags_q     <= '0;
      div_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      acc_q       <= acc_d;
      shf_q       <= shf_d;
      opb_q       <= opb_d;
      out_valid_q <= out_valid_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      flags_q     <= flags_d;
      div_err_q   <= div_err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_lo      = lo_q;
  assign out_hi      = hi_q;
  assign out_cf      = flags_q[5];
  assign out_pf      = flags_q[4];
  assign out_af      = flags_q[3];
  assign out_zf      = flags_q[2];
  assign out_sf      = flags_q[1];
  assign out_of      = flags_q[0];
  assign out_div_err = div_err_q;

endmodule

// File: tb/tb_cpu_8096_alu_seq.sv
// Testbench for cpu_8096_alu_seq: one DUT per WIDTH (8, 16, 32), each driven by
// its own directed + randomized sequence and checked against an arithmetic model.
module tb_cpu_8096_alu_seq;

  typedef struct packed {
    logic [63:0] lo;
    logic [63:0] hi;
    logic cf, pf, af, zf, sf, of, derr;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: integer arithmetic on w-bit values held in 64-bit containers.
  function automatic res_t ref_model(input int w, input int op, input logic [63:0] a,
                                     input logic [63:0] b, input bit cin);
    res_t        r;
    logic [63:0] m, msb, res, p, c;
    longint      sa, sb, s, lim, q, rm;
    r   = '0;
    m   = (64'd1 << w) - 64'd1;
    msb = 64'd1 << (w - 1);
    lim = longint'(msb);
    sa  = ((a & msb) != 64'd0) ? longint'(a) - 2 * lim : longint'(a);
    sb  = ((b & msb) != 64'd0) ? longint'(b) - 2 * lim : longint'(b);
    c   = (op == 1 || op == 3) ? 64'(cin) : 64'd0;
    res = 64'd0;
    case (op)
      0, 1: begin
        res  = (a + b + c) & m;
        r.cf = (a + b + c) > m;
        r.af = ((a & 64'd15) + (b & 64'd15) + c) > 64'd15;
        s    = sa + sb + longint'(c);
        r.of = (s >= lim) || (s < -lim);
      end
      2, 3, 7: begin
        res  = (a - b - c) & m;
        r.cf = a < (b + c);
        r.af = (a & 64'd15) < ((b & 64'd15) + c);
        s    = sa - sb - longint'(c);
        r.of = (s >= lim) || (s < -lim);
      end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      8: begin
        p    = a * b;
        r.lo = p & m;
        r.hi = (p >> w) & m;
        r.cf = (r.hi != 64'd0);
        r.of = r.cf;
      end
      9: begin
        s    = sa * sb;
        r.lo = 64'(s) & m;
        r.hi = 64'(s >>> w) & m;
        r.cf = (s >= lim) || (s < -lim);
        r.of = r.cf;
      end
      10: begin
        if (b == 64'd0) r.derr = 1'b1;
        else begin
          r.lo = a / b;
          r.hi = a % b;
        end
      end
      11: begin
        if (b == 64'd0 || (a == msb && b == m)) r.derr = 1'b1;
        else begin
          q    = sa / sb;
          rm   = sa % sb;
          r.lo = 64'(q) & m;
          r.hi = 64'(rm) & m;
        end
      end
      default: res = 64'd0;
    endcase
    if (op <= 7 || op >= 12) begin
      r.lo = (op == 7) ? a : res;
      r.sf = (res & msb) != 64'd0;
      r.zf = (res == 64'd0);
      r.pf = ~^res[7:0];
    end else if (op <= 9) begin
      r.sf = (r.lo & msb) != 64'd0;
      r.zf = (r.lo == 64'd0);
      r.pf = ~^r.lo[7:0];
    end
    return r;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_w
      localparam int W = (gi == 0) ? 8 : (gi == 1) ? 16 : 32;
      localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
      localparam logic [W-1:0] ALL_V = '1;

      logic         rst, in_valid, in_ready, in_cf, out_valid, out_ready;
      logic [3:0]   in_op;
      logic [W-1:0] in_a, in_b, out_lo, out_hi;
      logic         out_cf, out_pf, out_af, out_zf, out_sf, out_of, out_div_err;
      bit           done = 1'b0;

      cpu_8096_alu_seq #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cf       (in_cf),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_lo      (out_lo),
        .out_hi      (out_hi),
        .out_cf      (out_cf),
        .out_pf      (out_pf),
        .out_af      (out_af),
        .out_zf      (out_zf),
        .out_sf      (out_sf),
        .out_of      (out_of),
        .out_div_err (out_div_err)
      );

      function automatic logic [6:0] dut_flags();
        return {out_cf, out_pf, out_af, out_zf, out_sf, out_of, out_div_err};
      endfunction

      function automatic logic [6:0] exp_flags(input res_t e);
        return {e.cf, e.pf, e.af, e.zf, e.sf, e.of, e.derr};
      endfunction

      function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
          0:       return '0;
          1:       return MIN_V;
          2:       return ALL_V;
          3:       return W'(1);
          4:       return MIN_V - W'(1);
          default: return W'($urandom);
        endcase
      endfunction

      // Issue one op from IDLE, measure latency, hold for 'hold' cycles, then retire.
      task automatic issue(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit c, input int hold);
        res_t e;
        int   lat, want_lat;
        e        = ref_model(W, op, 64'(a), 64'(b), c);
        want_lat = (op >= 8 && op <= 11 && !e.derr) ? W + 1 : 1;
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'(op); in_a = a; in_b = b; in_cf = c; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_op = 4'($urandom); in_a = W'($urandom); in_b = W'($urandom);
        in_cf = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 4 * W) begin
          @(posedge clk);
          #1;
          lat++;
        end
        check($sformatf("w%0d op%0d latency", W, op), 64'(lat), 64'(want_lat));
        check($sformatf("w%0d op%0d lo", W, op), 64'(out_lo), e.lo);
        check($sformatf("w%0d op%0d hi", W, op), 64'(out_hi), e.hi);
        check($sformatf("w%0d op%0d flags", W, op), 64'(dut_flags()), 64'(exp_flags(e)));
        check($sformatf("w%0d op%0d in_ready_held", W, op), 64'(in_ready), 64'd0);
        for (int i = 0; i < hold; i++) begin
          @(posedge clk);
          #1;
          check($sformatf("w%0d op%0d hold_valid", W, op), 64'(out_valid), 64'd1);
          check($sformatf("w%0d op%0d hold_lo", W, op), 64'(out_lo), e.lo);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check($sformatf("w%0d op%0d retire_valid", W, op), 64'(out_valid), 64'd0);
        $display("w%0d op=%0d a=%0h b=%0h cf=%0b -> lo=%0h hi=%0h flags=%b lat=%0d",
                 W, op, a, b, c, out_lo, out_hi, dut_flags(), lat);
      endtask

      task automatic back_to_back();
        res_t         e1, e2;
        logic [W-1:0] a2, b2;
        e1 = ref_model(W, 6, 64'(MIN_V), 64'd5, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd6; in_a = MIN_V; in_b = W'(5); out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check($sformatf("w%0d b2b first_valid", W), 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
          @(posedge clk);
          #1;
          check($sformatf("w%0d b2b stall_lo", W), 64'(out_lo), e1.lo);
          check($sformatf("w%0d b2b stall_in_ready", W), 64'(in_ready), 64'd0);
          check($sformatf("w%0d b2b stall_valid", W), 64'(out_valid), 64'd1);
        end
        check($sformatf("w%0d b2b stall_flags", W), 64'(dut_flags()), 64'(exp_flags(e1)));
        a2 = pick();
        b2 = pick();
        e2 = ref_model(W, 0, 64'(a2), 64'(b2), 1'b1);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_op = 4'd0; in_a = a2; in_b = b2; in_cf = 1'b1;
        #1;
        check($sformatf("w%0d b2b in_ready", W), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check($sformatf("w%0d b2b second_valid", W), 64'(out_valid), 64'd1);
        check($sformatf("w%0d b2b second_lo", W), 64'(out_lo), e2.lo);
        check($sformatf("w%0d b2b second_flags", W), 64'(dut_flags()), 64'(exp_flags(e2)));
        @(posedge clk);
        #1;
        check($sformatf("w%0d b2b drain_valid", W), 64'(out_valid), 64'd0);
        $display("w%0d b2b xor=%0h then add %0h+%0h -> lo=%0h", W, e1.lo, a2, b2, out_lo);
      endtask

      task automatic reset_mid_div();
        int seen;
        seen = 0;
        @(negedge clk);
        in_valid = 1'b1; in_op = 4'd10; in_a = ALL_V; in_b = W'(3); out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check($sformatf("w%0d rst_busy valid", W), 64'(out_valid), 64'd0);
        check($sformatf("w%0d rst_busy in_ready", W), 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) begin
          @(posedge clk);
          #1;
          if (out_valid) seen++;
        end
        check($sformatf("w%0d rst_busy discarded", W), 64'(seen), 64'd0);
        $display("w%0d reset during DIV: valid pulses after release=%0d", W, seen);
        issue(0, W'(1), W'(1), 1'b0, 0);
      endtask

      initial begin
        rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; in_cf = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("w%0d reset valid", W), 64'(out_valid), 64'd0);
        check($sformatf("w%0d reset lo", W), 64'(out_lo), 64'd0);
        check($sformatf("w%0d reset hi", W), 64'(out_hi), 64'd0);
        check($sformatf("w%0d reset flags", W), 64'(dut_flags()), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check($sformatf("w%0d reset in_ready", W), 64'(in_ready), 64'd1);

        issue(0, MIN_V - W'(1), W'(1), 1'b0, 0);
        issue(3, '0, '0, 1'b1, 0);
        issue(7, W'(32'h1234), W'(32'h1234), 1'b0, 1);
        issue(8, W'(32'h1234), W'(32'h0100), 1'b0, 0);
        issue(8, ALL_V, ALL_V, 1'b0, 0);
        issue(9, ALL_V, ALL_V, 1'b0, 0);
        issue(9, MIN_V, MIN_V, 1'b0, 0);
        issue(11, W'(-7), W'(2), 1'b0, 0);
        issue(11, W'(7), W'(-2), 1'b0, 0);
        issue(10, W'(100), '0, 1'b0, 2);
        issue(11, MIN_V, ALL_V, 1'b0, 0);
        issue(11, MIN_V, W'(1), 1'b0, 0);
        issue(10, ALL_V, W'(7), 1'b0, 0);
        issue(13, pick(), pick(), 1'b1, 0);
        back_to_back();
        reset_mid_div();
        for (int n = 0; n < 40; n++)
          issue($urandom_range(0, 15), pick(), pick(), 1'($urandom), $urandom_range(0, 2));
        done = 1'b1;
      end
    end
  endgenerate

  initial begin
    for (int n = 0; n < 50000 && !(g_w[0].done && g_w[1].done && g_w[2].done); n++)
      @(posedge clk);
    check("all_suites_done", {61'd0, g_w[0].done, g_w[1].done, g_w[2].done}, 64'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
